to_affine_encode: RTL and testbench
===================================

TO_AFFINE_ENCODE -- requirements
Module: to_affine_encode

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 448 (from parameters_pkg), as the field element width; p = 2^448 - 2^224 - 1.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle request; samples x_in, y_in, z_in.
REQ-005 SHALL have ports x_in, y_in, z_in  input  DATA_WIDTH  projective coordinates (X:Y:Z), all < p.
REQ-006 SHALL have ports inv_start  output  1 and inv_a  output  DATA_WIDTH  request to the inv unit.
REQ-007 SHALL have ports inv_result  input  DATA_WIDTH and inv_done  input  1  response from the inv unit.
REQ-008 SHALL have ports mul_start  output  1 and mul_a, mul_b  output  DATA_WIDTH  request to the mod-p multiplier.
REQ-009 SHALL have ports mul_result  input  DATA_WIDTH and mul_done  input  1  response from the multiplier.
REQ-010 SHALL have port enc_out  output  DATA_WIDTH+8  57-byte Ed448 point encoding.
REQ-011 SHALL have ports done  output  1 (one-cycle pulse), busy  output  1, and error  output  1 (one-cycle pulse, with done).

Function
REQ-012 SHALL implement FSM states IDLE, INV_REQ, INV_WAIT, MULX_REQ, MULX_WAIT, MULY_REQ, MULY_WAIT, PACK, FIN.
REQ-013 IDLE: on start=1, SHALL register x_in/y_in/z_in and go to INV_REQ; z_in==0 instead goes to FIN with error flagged.
REQ-014 INV_REQ: SHALL drive inv_start=1 for exactly one cycle with inv_a=Z, then go to INV_WAIT.
REQ-015 INV_WAIT: SHALL latch inv_result into Zinv on the first cycle inv_done=1, then go to MULX_REQ; inv_done SHALL be ignored in all other states.
REQ-016 MULX_REQ: SHALL pulse mul_start with mul_a=X, mul_b=Zinv for one cycle; MULX_WAIT SHALL latch mul_result as x_aff on mul_done=1.
REQ-017 MULY_REQ/MULY_WAIT: SHALL behave as MULX with mul_a=Y, yielding y_aff.
REQ-018 PACK: SHALL load enc_out[447:0]=y_aff, enc_out[454:448]=0, enc_out[455]=x_aff[0].
REQ-019 FIN: SHALL assert done=1 for one cycle, then return to IDLE; on the z==0 path it SHALL also assert error=1 and load enc_out=0.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start while busy=1 SHALL be ignored; the captured operands SHALL not change.
REQ-022 With zero-wait peripherals (done in the cycle after the start pulse), done SHALL rise 8 cycles after the start cycle; error done SHALL rise 2 cycles after the start cycle.
REQ-023 Otherwise latency SHALL be 5 + inv wait cycles + two mul wait cycles; there is no timeout, and the WAIT states hold indefinitely.
REQ-024 enc_out SHALL hold its value until the next accepted start or reset.
REQ-025 inv_a, mul_a and mul_b SHALL stay stable from the request cycle until the corresponding done is accepted.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and set done, error, busy, inv_start, mul_start to 0 and enc_out, Zinv, x_aff, y_aff to 0.
REQ-027 Reset mid-operation SHALL abandon the operation without a done pulse; a late inv_done or mul_done arriving in IDLE SHALL be ignored.
REQ-028 rst SHALL have priority over a simultaneous start.

Verification
REQ-029 Z=1, X=5, Y=7, zero-wait behavioural inv/mul models -> done 8 cycles after start, enc_out={1'b1,7'b0,448'd7}, error=0.
REQ-030 X=Y=Z=0x123456789ABCDEF0 repeated to 448 bits, with inv returning 0x9379DC4C...E1F035 -> enc_out={1'b1,7'b0,448'd1}.
REQ-031 Z=0 -> done and error both high 2 cycles after start, enc_out=0, inv_start never asserted.
REQ-032 Inv model delays 20 cycles, mul model delays 3 cycles; a second start is pulsed during INV_WAIT -> exactly one done, at cycle 31, and operands unchanged.
REQ-033 rst asserted during MULX_WAIT, then mul_done arrives -> FSM in IDLE, no done, all outputs 0; a subsequent Z=1 operation completes correctly.

Source files
------------

// File: rtl/to_affine_encode.sv
// ---------------------------------------------------------------------------
// to_affine_encode
//
// Converts a projective Ed448 point (X:Y:Z) to affine form and packs it into
// the 57-byte point encoding: y in the low DATA_WIDTH bits, seven zero bits,
// then the parity of x in the top bit.  Field inversion and multiplication
// are delegated to external units through start/done handshakes.
//
// Ports
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start                 one-cycle request, samples x_in/y_in/z_in when idle
//   x_in, y_in, z_in      projective coordinates, each < p
//   inv_start, inv_a      request to the inversion unit (Z)
//   inv_result, inv_done  response from the inversion unit (Z^-1)
//   mul_start, mul_a/b    request to the mod-p multiplier
//   mul_result, mul_done  response from the multiplier
//   enc_out               packed encoding, held until the next accepted start
//   done                  one-cycle completion pulse
//   busy                  high in every state except IDLE
//   error                 one-cycle pulse alongside done when Z == 0
// ---------------------------------------------------------------------------
module to_affine_encode #(
    parameter int DATA_WIDTH = 448
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic [DATA_WIDTH-1:0] y_in,
    input  logic [DATA_WIDTH-1:0] z_in,
    output logic                  inv_start,
    output logic [DATA_WIDTH-1:0] inv_a,
    input  logic [DATA_WIDTH-1:0] inv_result,
    input  logic                  inv_done,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_b,
    input  logic [DATA_WIDTH-1:0] mul_result,
    input  logic                  mul_done,
    output logic [DATA_WIDTH+7:0] enc_out,
    output logic                  done,
    output logic                  busy,
    output logic                  error
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_INV_REQ   = 4'd1;
    localparam logic [3:0] ST_INV_WAIT  = 4'd2;
    localparam logic [3:0] ST_MULX_REQ  = 4'd3;
    localparam logic [3:0] ST_MULX_WAIT = 4'd4;
    localparam logic [3:0] ST_MULY_REQ  = 4'd5;
    localparam logic [3:0] ST_MULY_WAIT = 4'd6;
    localparam logic [3:0] ST_PACK      = 4'd7;
    localparam logic [3:0] ST_FIN       = 4'd8;

    logic [3:0]            state;
    logic [DATA_WIDTH-1:0] x_r;
    logic [DATA_WIDTH-1:0] y_r;
    logic [DATA_WIDTH-1:0] z_r;
    logic [DATA_WIDTH-1:0] zinv;
    logic [DATA_WIDTH-1:0] y_aff;
    // Only the parity of affine x enters the encoding, so only bit 0 is kept.
    logic                  x_aff_lsb;
    logic                  err_flag;

    // Request strobes and operands decode straight from the state register,
    // so the operands are stable for the whole request/wait window.
    always_comb begin
        inv_start = (state == ST_INV_REQ);
        mul_start = (state == ST_MULX_REQ) || (state == ST_MULY_REQ);
        busy      = (state != ST_IDLE);
        inv_a     = z_r;
        mul_b     = zinv;
        mul_a     = x_r;
        if (state == ST_MULY_REQ || state == ST_MULY_WAIT) begin
            mul_a = y_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            x_r       <= '0;
            y_r       <= '0;
            z_r       <= '0;
            zinv      <= '0;
            y_aff     <= '0;
            x_aff_lsb <= 1'b0;
            err_flag  <= 1'b0;
            enc_out   <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_r <= x_in;
                        y_r <= y_in;
                        z_r <= z_in;
                        if (z_in == '0) begin
                            err_flag <= 1'b1;
                            state    <= ST_FIN;
                        end else begin
                            err_flag <= 1'b0;
                            state    <= ST_INV_REQ;
                        end
                    end
                end
                ST_INV_REQ: state <= ST_INV_WAIT;
                ST_INV_WAIT: begin
                    if (inv_done) begin
                        zinv  <= inv_result;
                        state <= ST_MULX_REQ;
                    end
                end
                ST_MULX_REQ: state <= ST_MULX_WAIT;
                ST_MULX_WAIT: begin
                    if (mul_done) begin
                        x_aff_lsb <= mul_result[0];
                        state     <= ST_MULY_REQ;
                    end
                end
                ST_MULY_REQ: state <= ST_MULY_WAIT;
                ST_MULY_WAIT: begin
                    if (mul_done) begin
                        y_aff <= mul_result;
                        state <= ST_PACK;
                    end
                end
                ST_PACK: begin
                    // done is registered here so that it is high while in FIN.
                    enc_out <= {x_aff_lsb, 7'b0, y_aff};
                    done    <= 1'b1;
                    state   <= ST_FIN;
                end
                ST_FIN: begin
                    // The Z == 0 path reaches FIN straight from IDLE; its
                    // done/error pulse is registered here and shows one
                    // cycle later, after the return to IDLE.
                    if (err_flag) begin
                        done    <= 1'b1;
                        error   <= 1'b1;
                        enc_out <= '0;
                    end
                    err_flag <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_to_affine_encode.sv
module tb_to_affine_encode;

    localparam int W = 448;
    localparam logic [W-1:0] P = {{223{1'b1}}, 1'b0, {224{1'b1}}};

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   x_in, y_in, z_in;
    logic           inv_start;
    logic [W-1:0]   inv_a;
    logic [W-1:0]   inv_result;
    logic           inv_done;
    logic           mul_start;
    logic [W-1:0]   mul_a, mul_b;
    logic [W-1:0]   mul_result;
    logic           mul_done;
    logic [W+7:0]   enc_out;
    logic           done, busy, error;

    to_affine_encode #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .inv_start(inv_start), .inv_a(inv_a),
        .inv_result(inv_result), .inv_done(inv_done),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .mul_done(mul_done),
        .enc_out(enc_out), .done(done), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural peripheral models ----------------
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        logic [2*W-1:0] pw;
        logic [2*W-1:0] r;
        pw   = {{W{1'b0}}, P};
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r    = prod % pw;
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] invmod(input logic [W-1:0] a);
        logic [W-1:0] e, r, base;
        e    = P - 2;
        r    = 1;
        base = a;
        for (int i = 0; i < W; i++) begin
            if (e[i]) r = mulmod(r, base);
            base = mulmod(base, base);
        end
        return r;
    endfunction

    int inv_delay = 1;
    int mul_delay = 1;
    int inv_cnt = 0;
    int mul_cnt = 0;

    always @(posedge clk) begin
        if (inv_start) begin
            inv_cnt    <= inv_delay;
            inv_result <= invmod(inv_a);
        end else if (inv_cnt > 0) begin
            inv_cnt <= inv_cnt - 1;
        end
    end
    assign inv_done = (inv_cnt == 1);

    always @(posedge clk) begin
        if (mul_start) begin
            mul_cnt    <= mul_delay;
            mul_result <= mulmod(mul_a, mul_b);
        end else if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
        end
    end
    assign mul_done = (mul_cnt == 1);

    int done_cnt = 0;
    int inv_req_cnt = 0;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (inv_start) inv_req_cnt <= inv_req_cnt + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [W+7:0] obs, input logic [W+7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int s_cyc;

    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
        @(posedge clk); #1;
        x_in = x; y_in = y; z_in = z; start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns cycles from the start cycle to the cycle where done is high, or -1.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - s_cyc;
                break;
            end
        end
    endtask

    logic [W-1:0] k;
    logic [W+7:0] exp_enc;
    int lat, base_done, base_inv;

    initial begin
        rst = 1'b1; start = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        k = {7{64'h123456789ABCDEF0}};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_busy", busy, 0);
        check("rst_inv_start", inv_start, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_enc", enc_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Z=1, X=5, Y=7, zero-wait peripherals
        start_op(5, 7, 1);
        @(negedge clk);
        check("t1_busy", busy, 1);
        wait_done(lat);
        exp_enc = '0; exp_enc[W+7] = 1'b1; exp_enc[W-1:0] = 7;
        check("t1_latency", lat, 8);
        check("t1_enc", enc_out, exp_enc);
        check("t1_error", error, 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_enc_hold", enc_out, exp_enc);

        // X=Y=Z=K -> affine (1,1)
        start_op(k, k, k);
        wait_done(lat);
        exp_enc = '0; exp_enc[W+7] = 1'b1; exp_enc[W-1:0] = 1;
        check("t2_latency", lat, 8);
        check("t2_enc", enc_out, exp_enc);

        // Z=0 error path
        base_inv = inv_req_cnt;
        start_op(3, 4, 0);
        wait_done(lat);
        check("t3_latency", lat, 2);
        check("t3_error", error, 1);
        check("t3_enc", enc_out, 0);
        repeat (4) @(posedge clk);
        check("t3_no_inv", inv_req_cnt - base_inv, 0);

        // slow peripherals, ignored second start during INV_WAIT
        inv_delay = 20; mul_delay = 3;
        base_done = done_cnt;
        start_op(10, 14, 2);
        repeat (4) @(posedge clk); #1;
        x_in = 3; y_in = 3; z_in = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t4_inv_a_stable", inv_a, 2);
        wait_done(lat);
        exp_enc = '0; exp_enc[W+7] = 1'b1; exp_enc[W-1:0] = 7;
        check("t4_latency", lat, 31);
        check("t4_enc", enc_out, exp_enc);
        repeat (20) @(posedge clk);
        check("t4_one_done", done_cnt - base_done, 1);

        // reset during MULX_WAIT, with start on the reset cycle
        inv_delay = 1; mul_delay = 10;
        base_done = done_cnt;
        start_op(5, 7, 1);
        repeat (4) @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; x_in = 9; y_in = 9; z_in = 1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_error", error, 0);
        check("t5_inv_start", inv_start, 0);
        check("t5_mul_start", mul_start, 0);
        check("t5_enc", enc_out, 0);
        check("t5_inv_a", inv_a, 0);
        check("t5_mul_a", mul_a, 0);
        check("t5_mul_b", mul_b, 0);
        check("t5_no_done", done_cnt - base_done, 0);

        mul_delay = 1;
        start_op(4, 9, 1);
        wait_done(lat);
        exp_enc = '0; exp_enc[W-1:0] = 9;
        check("t5_after_latency", lat, 8);
        check("t5_after_enc", enc_out, exp_enc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
